// File: rtl/isp_pad_pkg.sv
// Shared types for the frame border inserter: FSM states and border-mode encodings.
package isp_pad_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRIME  = 3'd1,
        TOP    = 3'd2,
        BODY   = 3'd3,
        BOTTOM = 3'd4
    } pad_state_e;

    localparam logic PAD_ZERO = 1'b0;
    localparam logic PAD_REPL = 1'b1;

    // Pick the line-buffer column that supplies a border pixel in replicate mode.
    function automatic int unsigned edge_index(input int unsigned col,
                                               input int unsigned pad,
                                               input int unsigned width);
        int unsigned idx;
        if (col < pad) begin
            idx = 0;
        end else if (col >= pad + width) begin
            idx = width - 1;
        end else begin
            idx = col - pad;
        end
        return idx;
    endfunction

endpackage

// File: rtl/pad_line_buf.sv
// One-row pixel store for replicate mode: single write port, asynchronous read.
// A same-address write and read in one cycle returns the previous contents.
module pad_line_buf #(
    parameter int WIDTH  = 320,
    parameter int DATA_W = 24,
    parameter int AW     = 9
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:WIDTH-1];

    // Row storage; contents are meaningless until a frame primes them, so no reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/frame_pad_inserter.sv
// Streaming border inserter: WIDTH x HEIGHT in, (WIDTH+2*PAD) x (HEIGHT+2*PAD) out,
// constant or edge-replicated border. Define FRAME_PAD_STATS_EN for frame/stall counters.
module frame_pad_inserter
    import isp_pad_pkg::*;
#(
    parameter int                WIDTH     = 320,
    parameter int                HEIGHT    = 240,
    parameter int                PAD       = 1,
    parameter int                DATA_W    = 24,
    parameter logic [DATA_W-1:0] PAD_VALUE = {DATA_W{1'b0}}
) (
    input  logic              ctrl_clk,
    input  logic              reset_n,
    input  logic              pad_mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol,
    output logic              frame_done,
    output logic              busy
`ifdef FRAME_PAD_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int OUT_W = WIDTH + 2 * PAD;
    localparam int OUT_H = HEIGHT + 2 * PAD;
    localparam int COL_W = $clog2(OUT_W) + 1;
    localparam int ROW_W = $clog2(OUT_H) + 1;
    localparam int AW    = $clog2(WIDTH);

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(OUT_W - 1);
    localparam logic [COL_W-1:0] COL_PAD       = COL_W'(PAD);
    localparam logic [COL_W-1:0] COL_RIGHT     = COL_W'(PAD + WIDTH);
    localparam logic [COL_W-1:0] PRIME_LAST    = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_TOP_ZERO  = ROW_W'(PAD - 1);
    localparam logic [ROW_W-1:0] ROW_TOP_REPL  = ROW_W'(PAD);
    localparam logic [ROW_W-1:0] ROW_BODY_LAST = ROW_W'(PAD + HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(OUT_H - 1);

    pad_state_e        r_state;
    pad_state_e        w_next_state;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic              r_mode;
    logic [DATA_W-1:0] r_last_pix;
    logic              r_busy;
    logic              r_frame_done;

    logic              w_in_ready;
    logic              w_out_valid;
    logic [DATA_W-1:0] w_out_data;
    logic              w_out_sof;
    logic              w_out_eol;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_left;
    logic              w_right;
    logic              w_interior;
    logic              w_row_end;
    logic              w_emit;
    logic              w_frame_end;
    logic [ROW_W-1:0]  w_top_last;
    logic [AW-1:0]     w_col_idx;
    logic              w_buf_we;
    logic [AW-1:0]     w_buf_waddr;
    logic [AW-1:0]     w_buf_raddr;
    logic [DATA_W-1:0] w_buf_rdata;

    assign w_left      = (r_col < COL_PAD);
    assign w_right     = (r_col >= COL_RIGHT);
    assign w_interior  = !w_left && !w_right;
    assign w_row_end   = (r_col == COL_LAST);
    assign w_col_idx   = AW'(r_col - COL_PAD);
    assign w_in_fire   = in_valid && w_in_ready;
    assign w_out_fire  = w_out_valid && out_ready;
    assign w_emit      = (r_state == TOP) || (r_state == BODY) || (r_state == BOTTOM);
    assign w_top_last  = (r_mode == PAD_REPL) ? ROW_TOP_REPL : ROW_TOP_ZERO;
    assign w_frame_end = (r_state == BOTTOM) && w_out_fire && w_row_end && (r_row == ROW_LAST);
    assign w_buf_raddr = AW'(edge_index(32'(r_col), 32'(PAD), 32'(WIDTH)));

    pad_line_buf #(
        .WIDTH  (WIDTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_line_buf (
        .i_clk     (ctrl_clk),
        .i_wr_en   (w_buf_we),
        .i_wr_addr (w_buf_waddr),
        .i_wr_data (in_data),
        .i_rd_addr (w_buf_raddr),
        .o_rd_data (w_buf_rdata)
    );

    // Line-buffer write port: whole first row while priming, then each consumed body pixel.
    always_comb begin
        w_buf_we    = 1'b0;
        w_buf_waddr = w_col_idx;
        if (r_state == PRIME) begin
            w_buf_we    = w_in_fire;
            w_buf_waddr = r_col[AW-1:0];
        end else if ((r_state == BODY) && (r_mode == PAD_REPL)) begin
            w_buf_we    = w_in_fire;
            w_buf_waddr = w_col_idx;
        end else begin
            w_buf_we    = 1'b0;
            w_buf_waddr = w_col_idx;
        end
    end

    // FSM state register.
    always_ff @(posedge ctrl_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; every exit happens on the last transfer of its row span.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next_state = (pad_mode == PAD_REPL) ? PRIME : TOP;
                end else begin
                    w_next_state = IDLE;
                end
            end
            PRIME: begin
                if (w_in_fire && (r_col == PRIME_LAST)) begin
                    w_next_state = TOP;
                end else begin
                    w_next_state = PRIME;
                end
            end
            TOP: begin
                if (w_out_fire && w_row_end && (r_row == w_top_last)) begin
                    // A one-row replicate frame has no streamed body rows left.
                    w_next_state = (w_top_last == ROW_BODY_LAST) ? BOTTOM : BODY;
                end else begin
                    w_next_state = TOP;
                end
            end
            BODY: begin
                if (w_out_fire && w_row_end && (r_row == ROW_BODY_LAST)) begin
                    w_next_state = BOTTOM;
                end else begin
                    w_next_state = BODY;
                end
            end
            BOTTOM: begin
                if (w_frame_end) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = BOTTOM;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // FSM outputs: body interior is a zero-latency pass-through of the input stream.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_out_data  = PAD_VALUE;
        case (r_state)
            IDLE: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
                w_out_data  = PAD_VALUE;
            end
            PRIME: begin
                w_in_ready  = 1'b1;
            end
            TOP, BOTTOM: begin
                w_out_valid = 1'b1;
                w_out_data  = (r_mode == PAD_REPL) ? w_buf_rdata : PAD_VALUE;
            end
            BODY: begin
                if (w_interior) begin
                    w_out_valid = in_valid;
                    w_out_data  = in_data;
                    w_in_ready  = out_ready;
                end else if (w_left && (r_mode == PAD_REPL)) begin
                    // Show the upcoming first pixel without consuming it.
                    w_out_valid = in_valid;
                    w_out_data  = in_data;
                end else if (r_mode == PAD_REPL) begin
                    w_out_valid = 1'b1;
                    w_out_data  = r_last_pix;
                end else begin
                    w_out_valid = 1'b1;
                    w_out_data  = PAD_VALUE;
                end
            end
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
                w_out_data  = PAD_VALUE;
            end
        endcase
        w_out_sof = w_emit && (r_row == {ROW_W{1'b0}}) && (r_col == {COL_W{1'b0}});
        w_out_eol = w_emit && w_row_end;
    end

    // Output-coordinate counters (reused as the write index while priming).
    always_ff @(posedge ctrl_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col <= {COL_W{1'b0}};
            r_row <= {ROW_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    r_col <= {COL_W{1'b0}};
                    r_row <= {ROW_W{1'b0}};
                end
                PRIME: begin
                    if (w_in_fire) begin
                        r_col <= (r_col == PRIME_LAST) ? {COL_W{1'b0}} : r_col + COL_W'(1);
                    end
                end
                TOP, BODY, BOTTOM: begin
                    if (w_out_fire) begin
                        if (w_row_end) begin
                            r_col <= {COL_W{1'b0}};
                            r_row <= (r_row == ROW_LAST) ? {ROW_W{1'b0}} : r_row + ROW_W'(1);
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                default: begin
                    r_col <= {COL_W{1'b0}};
                    r_row <= {ROW_W{1'b0}};
                end
            endcase
        end
    end

    // Frame-level registers: latched mode, last body pixel, busy and done pulse.
    always_ff @(posedge ctrl_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode       <= PAD_ZERO;
            r_last_pix   <= PAD_VALUE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if ((r_state == IDLE) && in_valid) begin
                r_mode <= pad_mode;
            end
            if ((r_state == BODY) && w_in_fire) begin
                r_last_pix <= in_data;
            end
            if (w_frame_end) begin
                r_busy <= 1'b0;
            end else if ((r_state == IDLE) && in_valid) begin
                r_busy <= 1'b1;
            end
            r_frame_done <= w_frame_end;
        end
    end

`ifdef FRAME_PAD_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [31:0] r_stall_cnt;

    // Completed-frame count (wrapping) and saturating output-stall cycle count.
    always_ff @(posedge ctrl_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= 16'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (r_busy && w_out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_data   = w_out_data;
    assign out_sof    = w_out_sof;
    assign out_eol    = w_out_eol;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;

endmodule

// File: tb/tb_frame_pad_inserter.sv
// Randomised bench for frame_pad_inserter (4x3 frame, 1-pixel border) against a
// coordinate-based reference model of the padded raster.
module tb_frame_pad_inserter;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int P     = 1;
    localparam int DW    = 24;
    localparam logic [DW-1:0] PV = 24'h000000;
    localparam int OW    = W + 2 * P;
    localparam int OH    = H + 2 * P;
    localparam int NPIX  = W * H;
    localparam int NBEAT = OW * OH;

    logic          ctrl_clk = 1'b0;
    logic          reset_n  = 1'b0;
    logic          pad_mode = 1'b0;
    logic [DW-1:0] in_data  = 24'd0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_sof;
    logic          out_eol;
    logic          frame_done;
    logic          busy;
`ifdef FRAME_PAD_STATS_EN
    logic [15:0]   frame_cnt;
    logic [31:0]   stall_cnt;
`endif

    int            n_tests = 0;
    int            n_fail  = 0;
    int            frames_seen = 0;
    int            stall_exp = 0;
    logic [DW-1:0] pix [NPIX];

    frame_pad_inserter #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .PAD       (P),
        .DATA_W    (DW),
        .PAD_VALUE (PV)
    ) dut (
        .ctrl_clk   (ctrl_clk),
        .reset_n    (reset_n),
        .pad_mode   (pad_mode),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef FRAME_PAD_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial begin
        forever #5 ctrl_clk = ~ctrl_clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected pixel at output (r, c), derived from the padded-raster definition.
    function automatic logic [DW-1:0] model_pix(input logic mode, input int r, input int c);
        int ir;
        int ic;
        ir = r - P;
        ic = c - P;
        if (mode) begin
            ir = (ir < 0) ? 0 : ((ir > H - 1) ? H - 1 : ir);
            ic = (ic < 0) ? 0 : ((ic > W - 1) ? W - 1 : ic);
            return pix[ir * W + ic];
        end else if (ir < 0 || ir >= H || ic < 0 || ic >= W) begin
            return PV;
        end else begin
            return pix[ir * W + ic];
        end
    endfunction

    task automatic fill_seq();
        for (int i = 0; i < NPIX; i++) pix[i] = DW'(i + 1);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NPIX; i++) pix[i] = DW'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_out_valid"}, out_valid, 1'b0);
        check_eq({tag, "_in_ready"}, in_ready, 1'b0);
        check_eq({tag, "_sof"}, out_sof, 1'b0);
        check_eq({tag, "_eol"}, out_eol, 1'b0);
        check_eq({tag, "_done"}, frame_done, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_data"}, out_data, PV);
`ifdef FRAME_PAD_STATS_EN
        check_eq({tag, "_frame_cnt"}, frame_cnt, 32'd0);
        check_eq({tag, "_stall_cnt"}, stall_cnt, 32'd0);
`endif
    endtask

    function automatic logic ready_for(input int rdy_mode, input int cyc);
        case (rdy_mode)
            0: return 1'b1;
            1: return ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2: return 1'($urandom_range(0, 1));
            default: return !(cyc >= 12 && cyc < 22);
        endcase
    endfunction

    // One frame: drives the input stream, checks every output beat and the frame-end pulse.
    task automatic run_frame(input logic mode, input int rdy_mode, input int vpct, input int abort_at);
        int idx, beats, cyc, last_fire, r, c, ir;
        bit done, aborted, in_f, out_f, stalled;
        logic [DW-1:0] held_data;
        logic held_sof, held_eol, exp_rdy;
        idx = 0; beats = 0; cyc = 0; last_fire = -10;
        done = 0; aborted = 0; stalled = 0;
        held_data = PV; held_sof = 1'b0; held_eol = 1'b0;
        pad_mode = mode;
        out_ready = ready_for(rdy_mode, 0);
        while (!done && !aborted && cyc < 3000) begin
            @(negedge ctrl_clk);
            cyc++;
            in_f  = in_valid && in_ready;
            out_f = out_valid && out_ready;
            if (stalled) begin
                check_eq("stall_valid", out_valid, 1'b1);
                check_eq("stall_data", out_data, held_data);
                check_eq("stall_sof", out_sof, held_sof);
                check_eq("stall_eol", out_eol, held_eol);
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_sof  = out_sof;
            held_eol  = out_eol;
            if (busy && out_valid && !out_ready) stall_exp++;
            if (out_f) begin
                r = beats / OW;
                c = beats % OW;
                if (beats < NBEAT) begin
                    ir = r - P;
                    exp_rdy = (c >= P) && (c < P + W) && (ir >= (mode ? 1 : 0)) && (ir < H);
                    check_eq("data", out_data, model_pix(mode, r, c));
                    check_eq("sof", out_sof, beats == 0);
                    check_eq("eol", out_eol, c == OW - 1);
                    check_eq("busy", busy, 1'b1);
                    check_eq("in_ready", in_ready, exp_rdy);
                end else begin
                    check_eq("extra_beat", beats, NBEAT - 1);
                end
                last_fire = cyc;
                beats++;
            end
            if (frame_done) begin
                done = 1;
                frames_seen++;
                check_eq("done_beats", beats, NBEAT);
                check_eq("done_latency", cyc - last_fire, 1);
                check_eq("done_busy", busy, 1'b0);
                check_eq("done_inputs", idx + (in_f ? 1 : 0), NPIX);
            end
            if (!done && abort_at >= 0 && beats == abort_at) begin
                reset_n  = 1'b0;
                in_valid = 1'b0;
                #1;
                check_reset_outputs("abort");
                frames_seen = 0;
                stall_exp   = 0;
                repeat (3) @(posedge ctrl_clk);
                @(negedge ctrl_clk);
                reset_n = 1'b1;
                repeat (3) begin
                    @(negedge ctrl_clk);
                    check_eq("abort_no_done", frame_done, 1'b0);
                    check_eq("abort_idle_busy", busy, 1'b0);
                end
                aborted = 1;
            end
            if (!done && !aborted) begin
                @(posedge ctrl_clk);
                #1;
                if (in_f) idx++;
                if (busy) pad_mode = ~mode;
                if (in_f || !in_valid) begin
                    if (idx < NPIX && $urandom_range(0, 99) < vpct) begin
                        in_valid = 1'b1;
                        in_data  = pix[idx];
                    end else begin
                        in_valid = 1'b0;
                        in_data  = DW'($urandom);
                    end
                end
                out_ready = ready_for(rdy_mode, cyc);
            end
        end
        if (!done && !aborted) check_eq("timeout", 32'd0, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge ctrl_clk);
`ifdef FRAME_PAD_STATS_EN
        check_eq("frame_cnt", frame_cnt, 32'(frames_seen));
        check_eq("stall_cnt", stall_cnt, 32'(stall_exp));
`endif
    endtask

    initial begin
        int stall_before;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge ctrl_clk);
        @(negedge ctrl_clk);
        reset_n = 1'b1;

        fill_seq();
        run_frame(1'b0, 0, 100, -1);
        run_frame(1'b1, 0, 100, -1);
        run_frame(1'b1, 1, 60, -1);

        run_frame(1'b0, 0, 100, 14);
        run_frame(1'b0, 0, 100, -1);

        stall_before = stall_exp;
        run_frame(1'b0, 3, 100, -1);
        check_eq("stall_window", 32'(stall_exp - stall_before), 32'd10);

        for (int k = 0; k < 6; k++) begin
            fill_rand();
            run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(30, 100), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_pad_inserter.md
Name: frame_pad_inserter

Overview:
- Streaming border inserter between the camera pixel path and the SDRAM write FIFO.
- Takes a WIDTH x HEIGHT raster over valid/ready. Emits a (WIDTH+2*PAD) x (HEIGHT+2*PAD) raster with a border that is either a constant or edge-replicated.
- Generalises the fixed 1-pixel, 320x240 padding in the capture path.
- Single clock domain (ctrl_clk); one frame in flight at a time.

Parameters:
- WIDTH, 320: active pixels per input row.
- HEIGHT, 240: active rows per input frame.
- PAD, 1: border width on every side. Legal range 1..min(WIDTH-1, HEIGHT).
- DATA_W, 24: pixel width in bits.
- PAD_VALUE, 0: constant border pixel in zero mode.

Ports:
- ctrl_clk  in  1  clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- pad_mode  in  1  0 = constant border, 1 = replicate edge. Sampled at frame start.
- in_data  in  DATA_W  input pixel.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- out_data  out  DATA_W  output pixel.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts.
- out_sof  out  1  qualifies the first output pixel of a frame.
- out_eol  out  1  qualifies the last pixel of each output row.
- frame_done  out  1  one-cycle pulse after the last output pixel is accepted.
- busy  out  1  high from frame start until frame_done.

Behaviour:
- Reset: async assert. State=IDLE; row/col counters=0; mode register=0. out_valid, in_ready, out_sof, out_eol, frame_done and busy are all 0. out_data=PAD_VALUE. Line buffer contents are don't-care.
- Handshake rules:
  - A beat transfers only on valid && ready.
  - out_valid must not depend on out_ready.
  - out_data and flags stay stable while out_valid && !out_ready.
  - Input beats are consumed only in PRIME or in the BODY interior columns.
- Counters:
  - col in 0..WIDTH+2*PAD-1; row in 0..HEIGHT+2*PAD-1 (output coordinates).
  - Both advance on output transfer; col wraps to 0 and row increments at out_eol.
  - Widths are $clog2 of the maximum + 1.
- FSM: IDLE, PRIME, TOP, BODY, BOTTOM.
  - IDLE: on in_valid, latch pad_mode, busy=1. Go to PRIME if replicate, else TOP. Nothing consumed in IDLE.
  - PRIME (replicate only): in_ready=1, no output. Write WIDTH pixels into line buffer, then go to TOP.
  - TOP: emit PAD rows. Zero mode: all PAD_VALUE. Replicate: buffer row with edge extension. Replicate additionally emits row 0 from the buffer (PAD+1 rows total), then goes to BODY.
  - BODY: one output row per remaining input row. Count is HEIGHT in zero mode, HEIGHT-1 in replicate.
    - Left columns col<PAD: zero mode gives PAD_VALUE. Replicate presents in_data without consuming (in_ready=0, out_valid=in_valid).
    - Interior: out_data=in_data, out_valid=in_valid, in_ready=out_ready (zero latency, combinational). Each transferred pixel updates the last_pix register and, in replicate mode, line buffer[col-PAD].
    - Right columns: zero mode gives PAD_VALUE; replicate gives last_pix.
  - BOTTOM: PAD rows. Zero mode gives PAD_VALUE. Replicate gives the buffer (last input row), edge extended.
  - After the final transfer: frame_done pulse, busy=0, IDLE.
- Line buffer: WIDTH x DATA_W with asynchronous read (LUTRAM). Write and read of the same address in one cycle returns the old data.
- Edge flags: out_sof when row=0 && col=0; out_eol when col=WIDTH+2*PAD-1.
- Mode changes mid-frame are ignored.
- Input stall in BODY stalls output; output stall in TOP/BOTTOM holds in_ready=0.
- Reset mid-frame: abort immediately, no frame_done. The next frame starts clean from IDLE.

Optional Feature:
- FRAME_PAD_STATS_EN defined: adds outputs frame_cnt[15:0] and stall_cnt[31:0], both reset to 0.
  - frame_cnt increments on each frame_done and wraps at 0xFFFF.
  - stall_cnt counts cycles with out_valid && !out_ready while busy, and saturates.
- FRAME_PAD_STATS_EN undefined: ports and logic are absent.

Decomposition:
- Package isp_pad_pkg holds: typedef pad_state_e (IDLE, PRIME, TOP, BODY, BOTTOM) and the pad_mode encodings PAD_ZERO=0, PAD_REPL=1.
- One sub-module, pad_line_buf: parameterised WIDTH x DATA_W single-write, async-read array.

Test Plan:
- WIDTH=4, HEIGHT=3, PAD=1, zero mode, input pixels 1..12, out_ready=1:
  - 30 beats out.
  - Row0 = 0,0,0,0,0,0.
  - Row1 = 0,1,2,3,4,0.
  - Row4 all 0.
  - out_sof on beat 0; out_eol on beats 5,11,..,29; frame_done 1 cycle after beat 29.
- Same config, replicate mode:
  - Rows 0 and 1 = 1,1,2,3,4,4.
  - Row 3 = 9,9,10,11,12,12; row 4 = row 3.
  - in_ready=0 on the left-pad beat of rows 2..3.
- Replicate mode with out_ready toggling 1,0,0,1 and in_valid random: identical 30-beat sequence, and out_data stable during every stall.
- reset_n low at output beat 14 of a zero-mode frame:
  - All outputs 0 within the reset.
  - Next frame 1..12 yields the correct 30-beat sequence.
  - No frame_done for the aborted frame.
- Default parameters, zero mode, 76800 pixels (values 1..76800): 77924 output beats; beat 323 = 1; beat 77600 = 76800.
- With FRAME_PAD_STATS_EN: 3 back-to-back frames give frame_cnt=3; out_ready held low 10 cycles mid-frame gives stall_cnt=10.
